adder_op_sequencer: RTL and testbench

// - Handshaked operand/result sequencer that wraps the combinational ripple-carry Adder.
// - Upstream side: accepts (a,b) pairs over valid/ready and registers them onto add_a/add_b.
// - Holds the operands stable for a programmable settle window (slow RHBD ripple path).
// - Downstream side: captures add_y into a result register and presents it over valid/ready.

---
 rtl/adder_op_sequencer.sv | 133 +++++++++++++
 tb/tb_adder_op_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_op_sequencer.sv
// Operand/result sequencer around a combinational ripple-carry adder: upstream valid/ready in, downstream valid/ready out.
// Latency: pair accepted in cycle N -> out_valid first high in cycle N+2+SETTLE_CYCLES; one result per SETTLE_CYCLES+3 cycles.
// Backpressure: in_ready is low from accept until the result is taken; out_sum holds while out_ready is low. Option macro: ADDER_SEQ_CARRY_EN adds out_carry.
module adder_op_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum
`ifdef ADDER_SEQ_CARRY_EN
  ,
  output logic             out_carry
`endif
);

  // Counter needs at least one bit even when there is no settle window.
  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
`ifdef ADDER_SEQ_CARRY_EN
  logic             out_carry_q, out_carry_d;
`endif

  // Next-state logic: operands only move on an IDLE accept, result only on settle expiry.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
`ifdef ADDER_SEQ_CARRY_EN
    out_carry_d = out_carry_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          add_a_d    = in_a;
          add_b_d    = in_b;
          cnt_d      = CNT_INIT;
          in_ready_d = 1'b0;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          out_sum_d   = add_y;
`ifdef ADDER_SEQ_CARRY_EN
          // A wrapped unsigned sum is smaller than either operand.
          out_carry_d = (add_y < add_a_q);
`endif
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        // in_ready rises only in the cycle after the result leaves: no pass-through.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset drops any in-flight pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
`ifdef ADDER_SEQ_CARRY_EN
      out_carry_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
`ifdef ADDER_SEQ_CARRY_EN
      out_carry_q <= out_carry_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
`ifdef ADDER_SEQ_CARRY_EN
  assign out_carry = out_carry_q;
`endif

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Directed bench for adder_op_sequencer: one instance with SETTLE_CYCLES=2, one with SETTLE_CYCLES=0.
// Each instance is closed around a behavioural adder (add_y = add_a + add_b, modulo 256).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_adder_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with SETTLE_CYCLES=2
  logic       r2, iv2, ir2, ov2, or2;
  logic [7:0] a2, b2, aa2, ab2, y2, s2;
  logic       c2;
  // Instance with SETTLE_CYCLES=0
  logic       r0, iv0, ir0, ov0, or0;
  logic [7:0] a0, b0, aa0, ab0, y0, s0;
  logic       c0;

  assign y2 = aa2 + ab2;
  assign y0 = aa0 + ab0;

  adder_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(2)) u_seq2 (
    .clk(clk), .reset(r2), .in_valid(iv2), .in_ready(ir2), .in_a(a2), .in_b(b2),
    .add_a(aa2), .add_b(ab2), .add_y(y2), .out_valid(ov2), .out_ready(or2), .out_sum(s2)
`ifdef ADDER_SEQ_CARRY_EN
    , .out_carry(c2)
`endif
  );

  adder_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(0)) u_seq0 (
    .clk(clk), .reset(r0), .in_valid(iv0), .in_ready(ir0), .in_a(a0), .in_b(b0),
    .add_a(aa0), .add_b(ab0), .add_y(y0), .out_valid(ov0), .out_ready(or0), .out_sum(s0)
`ifdef ADDER_SEQ_CARRY_EN
    , .out_carry(c0)
`endif
  );

`ifndef ADDER_SEQ_CARRY_EN
  assign c2 = 1'b0;
  assign c0 = 1'b0;
`endif

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the SETTLE_CYCLES=2 instance with hand-computed results.
  task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_sum, input logic exp_carry);
    int w;
    w = 0;
    while (!ir2 && w < 20) begin
      step();
      w++;
    end
    chk({tag, "_in_ready"}, 32'(ir2), 32'd1);
    a2  = a;
    b2  = b;
    iv2 = 1'b1;
    step();              // accept edge; now in cycle N+1
    iv2 = 1'b0;
    chk({tag, "_add_a"}, 32'(aa2), 32'(a));
    chk({tag, "_add_b"}, 32'(ab2), 32'(b));
    w = 1;
    while (!ov2 && w < 20) begin
      step();
      w++;
    end
    chk({tag, "_latency"}, 32'(w), 32'd4);
    chk({tag, "_sum"}, 32'(s2), 32'(exp_sum));
`ifdef ADDER_SEQ_CARRY_EN
    chk({tag, "_carry"}, 32'(c2), 32'(exp_carry));
`endif
    or2 = 1'b1;
    step();
    or2 = 1'b0;
    chk({tag, "_drop_valid"}, 32'(ov2), 32'd0);
    step();
    chk({tag, "_ready_back"}, 32'(ir2), 32'd1);
  endtask

  logic [8:0] exp_q[$];
  logic [8:0] e;

  initial begin
    int got, cyc, last;
    logic hs;
    r2 = 1'b1; iv2 = 1'b0; or2 = 1'b0; a2 = '0; b2 = '0;
    r0 = 1'b1; iv0 = 1'b0; or0 = 1'b0; a0 = '0; b0 = '0;

    // Reset state
    step();
    step();
    chk("rst_in_ready", 32'(ir2), 32'd0);
    chk("rst_out_valid", 32'(ov2), 32'd0);
    chk("rst_out_sum", 32'(s2), 32'd0);
    chk("rst_add_a", 32'(aa2), 32'd0);
    chk("rst_add_b", 32'(ab2), 32'd0);
    r2 = 1'b0;
    r0 = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(ir2), 32'd1);
    chk("post_rst_out_valid", 32'(ov2), 32'd0);
    chk("post_rst_in_ready0", 32'(ir0), 32'd1);

    // Main function and wrap cases
    run_add("single", 8'h12, 8'h34, 8'h46, 1'b0);
    run_add("wrap", 8'hFF, 8'h02, 8'h01, 1'b1);
    run_add("nowrap", 8'h7F, 8'h01, 8'h80, 1'b0);

    // Backpressure: hold result 10 cycles while upstream keeps offering a pair
    a2 = 8'h20; b2 = 8'h22; iv2 = 1'b1;
    step();
    a2 = 8'hAA; b2 = 8'hBB;
    begin
      int w;
      w = 0;
      while (!ov2 && w < 20) begin
        step();
        w++;
      end
    end
    chk("bp_valid", 32'(ov2), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_sum_hold", 32'(s2), 32'h42);
      chk("bp_valid_hold", 32'(ov2), 32'd1);
      chk("bp_in_ready", 32'(ir2), 32'd0);
      chk("bp_add_a_hold", 32'(aa2), 32'h20);
    end
    iv2 = 1'b0;
    or2 = 1'b1;
    step();
    or2 = 1'b0;
    chk("bp_release_valid", 32'(ov2), 32'd0);
    chk("bp_release_ready", 32'(ir2), 32'd1);
    chk("bp_add_a_kept", 32'(aa2), 32'h20);

    // Reset one cycle after an accept: the pair is dropped
    a2 = 8'h55; b2 = 8'h11; iv2 = 1'b1;
    step();
    iv2 = 1'b0;
    r2 = 1'b1;
    step();
    r2 = 1'b0;
    chk("midrst_add_a", 32'(aa2), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("midrst_valid", 32'(ov2), 32'd0);
      chk("midrst_sum", 32'(s2), 32'd0);
      step();
    end
    run_add("after_rst", 8'h05, 8'h03, 8'h08, 1'b0);

    // Back-to-back on the SETTLE_CYCLES=0 instance, one result every 3 cycles
    got  = 0;
    cyc  = 0;
    last = -1;
    iv0  = 1'b1;
    or0  = 1'b1;
    a0   = 8'($urandom_range(0, 255));
    b0   = 8'($urandom_range(0, 255));
    while (got < 1000 && cyc < 5000) begin
      hs = ir0;
      if (ov0) begin
        if (exp_q.size() == 0) begin
          chk("b2b_spurious", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("b2b_sum", 32'(s0), 32'(e[7:0]));
`ifdef ADDER_SEQ_CARRY_EN
          chk("b2b_carry", 32'(c0), 32'(e[8]));
`endif
        end
        if (last >= 0) chk("b2b_gap", 32'(cyc - last), 32'd3);
        last = cyc;
        got++;
      end
      if (hs) exp_q.push_back({1'b0, a0} + {1'b0, b0});
      step();
      cyc++;
      if (hs) begin
        a0 = 8'($urandom_range(0, 255));
        b0 = 8'($urandom_range(0, 255));
      end
    end
    chk("b2b_count", 32'(got), 32'd1000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
